// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the active-low rows, debounces press and release
// of one latched key, and reports its hex code with a single-cycle strobe.
module keypad_scanner #(
  parameter int ROW_DWELL       = 4096,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam int DW = $clog2(ROW_DWELL);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    rows_q, rows_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] db_q, db_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          col_level;

  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd3;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  assign col_level = cols[col_q];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        // dwell_q == 0 is the settling cycle of a freshly driven row
        if ((dwell_q != '0) && (cols != 4'hF)) begin
          col_d   = lowest_low(cols);
          db_d    = '0;
          state_d = PRESS_DB;
        end else if (dwell_q == DWELL_LAST) begin
          row_d   = row_q + 2'd1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (col_level) begin
          row_d   = row_q + 2'd1;
          dwell_d = '0;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          key_code_d  = key_map(row_q, col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (col_level) begin
          db_d    = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (!col_level) begin
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          key_held_d = 1'b0;
          row_d      = row_q + 2'd1;
          dwell_d    = '0;
          state_d    = SCAN;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
    rows_d = ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      rows_q      <= 4'b1110;
      dwell_q     <= '0;
      db_q        <= '0;
      col_q       <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rows_q      <= rows_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // key_valid is a bare strobe with no backpressure: the consumer takes key_code in
  // the one cycle key_valid is high; key_code then stays stable until the next key.
  assign rows        = rows_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives cols from rows, and a
// timestamp-based reference model predicts every output cycle by cycle.
module tb_keypad_scanner;

  localparam int ROW_DWELL       = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cols;
  wire  [3:0] rows;
  wire  [3:0] key_code;
  wire        key_valid;
  wire        key_held;
  wire  [1:0] dbg_state;

  logic [15:0] pressed = '0;
  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  keypad_scanner #(
    .ROW_DWELL       (ROW_DWELL),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cols        (cols),
    .rows        (rows),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .dbg_state_o (dbg_state)
  );

  // physical keypad: a pressed key at (r,c) pulls cols[c] low while row r is driven low
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (rows[r] === 1'b0)) cols[c] = 1'b0;
  end

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  function automatic int first_low(input logic [3:0] c);
    int idx;
    idx = 0;
    for (int i = 3; i >= 0; i--) if (!c[i]) idx = i;
    return idx;
  endfunction

  // reference model: edge counter plus timestamps of row start, latch and release start
  int         m_n = 0, m_row = 0, m_since = 0, m_mode = 0, m_col = 0, m_latch = 0, m_hs = 0;
  logic [3:0] m_code = 4'h0;
  logic       m_valid = 1'b0, m_held = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  always @(posedge clk) begin : ref_model
    int n, row, since, mode, col, latch, hs, age;
    logic [3:0] code;
    logic held, valid;
    n = m_n + 1; row = m_row; since = m_since; mode = m_mode; col = m_col;
    latch = m_latch; hs = m_hs; code = m_code; held = m_held; valid = 1'b0;
    if (reset) begin
      row = 0; since = n; mode = 0; code = 4'h0; held = 1'b0;
    end else begin
      case (mode)
        0: begin
          age = n - since - 1;
          if (age != 0 && cols != 4'hF) begin
            col = first_low(cols); latch = n; mode = 1;
          end else if (age == ROW_DWELL - 1) begin
            row = (row + 1) % 4; since = n;
          end
        end
        1: begin
          if (cols[col]) begin
            row = (row + 1) % 4; since = n; mode = 0;
          end else if (n - latch == DEBOUNCE_CYCLES) begin
            code = keymap[row*4+col]; held = 1'b1; valid = 1'b1; mode = 2;
            exp_q.push_back(code);
          end
        end
        2: if (cols[col]) begin hs = n; mode = 3; end
        default: begin
          if (!cols[col]) mode = 2;
          else if (n - hs == DEBOUNCE_CYCLES) begin
            held = 1'b0; row = (row + 1) % 4; since = n; mode = 0;
          end
        end
      endcase
    end
    m_n <= n; m_row <= row; m_since <= since; m_mode <= mode; m_col <= col;
    m_latch <= latch; m_hs <= hs; m_code <= code; m_held <= held; m_valid <= valid;
  end

  wire  [9:0] obs = {rows, key_code, key_valid, key_held};
  logic [9:0] exp_v;
  logic [3:0] exp_rows;
  always_comb begin
    exp_rows = ~(4'b0001 << m_row[1:0]);
    exp_v    = {exp_rows, m_code, m_valid, m_held};
  end

  // observed strobes, sampled shortly after each edge
  int dut_valids = 0;
  int v_n = 0;
  always @(posedge clk) begin
    #2;
    if (key_valid === 1'b1) begin
      got_q.push_back(key_code);
      dut_valids = dut_valids + 1;
      v_n = m_n;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_values got=%h exp=%h", obs, {4'b1110, 4'h0, 1'b0, 1'b0});
    end
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int v0 = dut_valids;
    logic [3:0] er;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      er = ~(4'b0001 << ((k / 4) % 4));
      n_cmp++;
      if (rows !== er) begin n_bad++; $display("FAIL idle_rows k=%0d got=%b exp=%b", k, rows, er); end
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL idle_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids != v0) begin n_bad++; $display("FAIL idle_valids got=%0d exp=%0d", dut_valids - v0, 0); end
  endtask

  task automatic test_press_key5();
    int v0 = dut_valids;
    pressed[5] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL key5_model n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids - v0 != 1) begin n_bad++; $display("FAIL key5_valid_count got=%0d exp=1", dut_valids - v0); end
    n_cmp++;
    if (rows !== 4'b1101) begin n_bad++; $display("FAIL key5_rows got=%b exp=1101", rows); end
    n_cmp++;
    if (key_code !== 4'h5 || key_held !== 1'b1) begin
      n_bad++; $display("FAIL key5_code_held got=%h/%b exp=5/1", key_code, key_held);
    end
    n_cmp++;
    if (v_n - m_latch != DEBOUNCE_CYCLES) begin
      n_bad++; $display("FAIL key5_latency got=%0d exp=%0d", v_n - m_latch, DEBOUNCE_CYCLES);
    end
    pressed = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL key5_release n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (key_held !== 1'b0) begin n_bad++; $display("FAIL key5_held_end got=%b exp=0", key_held); end
  endtask

  task automatic test_bounce();
    int v0 = dut_valids;
    logic [3:0] prev = rows;
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL bounce_wait n=%0d got=%h exp=%h", m_n, obs, exp_v); end
      if (prev != 4'b1110 && rows == 4'b1110) found = 1;
      prev = rows;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL bounce_row0_timeout got=%b exp=1110", rows); end
    pressed[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL bounce_low n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    pressed[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rows !== 4'b1101) begin n_bad++; $display("FAIL bounce_next_row got=%b exp=1101", rows); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL bounce_after n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids != v0) begin n_bad++; $display("FAIL bounce_valids got=%0d exp=0", dut_valids - v0); end
  endtask

  task automatic test_release_bounce();
    int v0 = dut_valids;
    int plan [3] = '{4, 2, 0};
    pressed[10] = 1'b1;
    for (int i = 0; i < 60 && dut_valids == v0; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL key9_wait n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids == v0) begin n_bad++; $display("FAIL key9_timeout got=0 exp=1"); end
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      pressed[10] = (p == 1);
      for (int i = 0; i < plan[p]; i++) begin
        @(negedge clk);
        n_cmp++;
        if (obs !== exp_v || key_held !== 1'b1) begin
          n_bad++; $display("FAIL key9_bounce n=%0d got=%h exp=%h", m_n, obs, exp_v);
        end
      end
    end
    pressed[10] = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      n_cmp++;
      if (key_held !== (m <= DEBOUNCE_CYCLES)) begin
        n_bad++; $display("FAIL key9_held m=%0d got=%b exp=%b", m, key_held, m <= DEBOUNCE_CYCLES);
      end
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL key9_release n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids - v0 != 1 || key_code !== 4'h9) begin
      n_bad++; $display("FAIL key9_summary got=%0d/%h exp=1/9", dut_valids - v0, key_code);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int v0 = dut_valids;
    bit found = 0;
    pressed[15] = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL keyD_wait n=%0d got=%h exp=%h", m_n, obs, exp_v); end
      if (m_mode == 1 && (m_n - m_latch) == 5) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL keyD_latch_timeout got=0 exp=1"); end
    reset = 1'b1;
    pressed = '0;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (obs !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL keyD_reset got=%h exp=%h", obs, {4'b1110, 4'h0, 1'b0, 1'b0});
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL keyD_after n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids != v0) begin n_bad++; $display("FAIL keyD_valids got=%0d exp=0", dut_valids - v0); end
  endtask

  task automatic test_two_keys();
    int v0 = dut_valids;
    bit found = 0;
    pressed[8]  = 1'b1;
    pressed[11] = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL two_keys n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (dut_valids - v0 != 1 || key_code !== 4'h7) begin
      n_bad++; $display("FAIL two_keys_code got=%0d/%h exp=1/7", dut_valids - v0, key_code);
    end
    pressed = '0;
    repeat (12) @(negedge clk);
    v0 = dut_valids;
    pressed[6] = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_mode == 1) found = 1;
    end
    pressed[4] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL lower_col n=%0d got=%h exp=%h", m_n, obs, exp_v); end
    end
    n_cmp++;
    if (!found || dut_valids - v0 != 1 || key_code !== 4'h6) begin
      n_bad++; $display("FAIL lower_col_code got=%0d/%h exp=1/6", dut_valids - v0, key_code);
    end
    pressed = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int hold, gap;
    for (int it = 0; it < 25; it++) begin
      pressed[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 30);
      gap  = $urandom_range(1, 30);
      for (int i = 0; i < hold + gap; i++) begin
        if (i == hold) pressed = '0;
        @(negedge clk);
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL random it=%0d n=%0d got=%h exp=%h", it, m_n, obs, exp_v); end
      end
    end
    pressed = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_scoreboard();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL sb_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sb_code idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press_key5();
    test_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    test_two_keys();
    test_random();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
